// File: rtl/color_seq_ctrl.sv
// color_seq_ctrl
//   Steps through a small RGB888 color table at a selectable rate and drives
//   three PWM LED outputs from the currently displayed color.
//
// Ports
//   clk, rst_n        : single clock, asynchronous active-low reset
//   start / stop      : one-cycle commands (stop > start > pause)
//   pause             : level, freezes the sequence while high
//   rate_sel[1:0]     : step rate = BASE_HZ << rate_sel
//   wr_en/addr/data   : color-table write port, accepted when wr_en && wr_ready
//   wr_ready          : low only in a cycle whose next edge advances the step
//   color[23:0]       : displayed RGB888 value (0 while idle)
//   step_idx[2:0]     : current table index
//   step_tick         : one-cycle pulse after each step advance
//   running           : high in RUN or PAUSE
//   led_r/g/b         : PWM outputs, duty = channel byte / 256
module color_seq_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int BASE_HZ   = 1,
    parameter int NUM_STEPS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic [1:0]  rate_sel,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [23:0] wr_data,
    output logic        wr_ready,
    output logic [23:0] color,
    output logic [2:0]  step_idx,
    output logic        step_tick,
    output logic        running,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b
);

    localparam int DIV = CLK_HZ / BASE_HZ;
    // Prescaler and terminal share one width wide enough to hold DIV itself.
    localparam int TW = (DIV > 1) ? $clog2(DIV + 1) : 1;
    localparam logic [TW-1:0] DIV_V    = TW'(DIV);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_STEPS - 1);
    localparam logic [3:0]    NS_V     = 4'(NUM_STEPS);

    // Entry 0 sits in the low bits.
    localparam logic [7:0][23:0] TAB_RST = {
        24'h000000, 24'hFFFFFF, 24'hFF00FF, 24'h00FFFF,
        24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      color_q, color_d;
    logic             tick_q, tick_d;
    logic [7:0]       pwm_q, pwm_d;
    logic [7:0][23:0] tab_q, tab_d;

    logic [TW-1:0] term, term_m1;
    logic          active, adv, wr_acc;
    logic [2:0]    idx_nx;

    // Rate changes act immediately; a terminal of zero (huge rate_sel with a
    // tiny divider) degenerates to ticking every cycle.
    assign term    = DIV_V >> rate_sel;
    assign term_m1 = (term == '0) ? '0 : term - TW'(1);

    assign active = (state_q != S_IDLE);
    // The >= lets a count left over-range by a rate change tick at once.
    assign adv    = active && !stop && !start && !pause && (presc_q >= term_m1);
    assign idx_nx = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;

    // Writes stall on the advancing edge so the new color never races the
    // table lookup for the next index.
    assign wr_ready = !adv;
    assign wr_acc   = wr_en && wr_ready && ({1'b0, wr_addr} < NS_V);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        color_d = color_q;
        tick_d  = 1'b0;
        tab_d   = tab_q;
        pwm_d   = pwm_q + 8'd1;

        if (wr_acc) tab_d[wr_addr] = wr_data;

        if (stop) begin
            state_d = S_IDLE;
            presc_d = '0;
            idx_d   = '0;
            color_d = '0;
        end else if (start) begin
            state_d = S_RUN;
            presc_d = '0;
            idx_d   = '0;
            // Bypass a same-cycle write to entry 0.
            color_d = (wr_acc && wr_addr == 3'd0) ? wr_data : tab_q[0];
        end else if (active) begin
            state_d = pause ? S_PAUSE : S_RUN;
            if (adv) begin
                tick_d  = 1'b1;
                presc_d = '0;
                idx_d   = idx_nx;
                color_d = tab_q[idx_nx];
            end else begin
                if (!pause) presc_d = presc_q + TW'(1);
                if (wr_acc && wr_addr == idx_q) color_d = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            color_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            tab_q   <= TAB_RST;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            tab_q   <= tab_d;
        end
    end

    // One comparator per channel: [2]=R, [1]=G, [0]=B.
    logic [2:0][7:0] chan;
    logic [2:0]      led;
    assign chan = color_q;

    for (genvar c = 0; c < 3; c++) begin : g_pwm
        assign led[c] = (pwm_q < chan[c]);
    end

    assign {led_r, led_g, led_b} = led;
    assign color     = color_q;
    assign step_idx  = idx_q;
    assign step_tick = tick_q;
    assign running   = active;

endmodule

// File: tb/tb_color_seq_ctrl.sv
// Testbench for color_seq_ctrl (CLK_HZ=16, BASE_HZ=1 -> 16 cycles per step at
// rate_sel=0). A cycle-level reference model tracks the expected outputs.
module tb_color_seq_ctrl;

    localparam int NS = 8;
    localparam logic [23:0] RST_TAB [NS] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
        24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'h000000
    };

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [1:0]  rate_sel = 2'd0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [23:0] wr_data = 24'd0;
    logic        wr_ready, step_tick, running, led_r, led_g, led_b;
    logic [23:0] color;
    logic [2:0]  step_idx;

    always #5 clk = ~clk;

    color_seq_ctrl #(.CLK_HZ(16), .BASE_HZ(1), .NUM_STEPS(NS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .rate_sel(rate_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .color(color), .step_idx(step_idx),
        .step_tick(step_tick), .running(running),
        .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    int ncmp = 0, nfail = 0;

    // Reference model state
    bit          m_act, m_tick;
    int          m_cnt, m_idx, m_pwm;
    logic [23:0] m_tab [NS];
    logic [23:0] m_color;
    logic        pre_ready;
    bit          exp_ready;

    logic [31:0] dv;
    assign dv = {color, step_idx, step_tick, running, led_r, led_g, led_b};

    function automatic void model_reset();
        m_act = 0; m_tick = 0; m_cnt = 0; m_idx = 0; m_pwm = 0; m_color = '0;
        m_tab = RST_TAB;
    endfunction

    // Does the next edge complete a step period?
    function automatic bit model_adv();
        int t = 16 >> rate_sel;
        return m_act && !stop && !start && !pause && (m_cnt + 1 >= t);
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [7:0] p = 8'(m_pwm);
        return {m_color, 3'(m_idx), m_tick, m_act,
                p < m_color[23:16], p < m_color[15:8], p < m_color[7:0]};
    endfunction

    // One clock: sample wr_ready before the edge, advance the model on the
    // edge, return 1 time unit later. Inputs change only between calls.
    task automatic clk_cycle();
        bit adv, acc;
        @(negedge clk);
        pre_ready = wr_ready;
        exp_ready = !model_adv();
        @(posedge clk);
        adv = model_adv();
        acc = wr_en && !adv;
        m_tick = 0;
        if (stop) begin
            m_act = 0; m_cnt = 0; m_idx = 0; m_color = '0;
        end else if (start) begin
            m_act = 1; m_cnt = 0; m_idx = 0;
            m_color = (acc && wr_addr == 0) ? wr_data : m_tab[0];
        end else if (m_act) begin
            if (adv) begin
                m_tick = 1; m_cnt = 0; m_idx = (m_idx + 1) % NS; m_color = m_tab[m_idx];
            end else begin
                if (!pause) m_cnt++;
                if (acc && int'(wr_addr) == m_idx) m_color = wr_data;
            end
        end
        if (acc && int'(wr_addr) < NS) m_tab[wr_addr] = wr_data;
        m_pwm = (m_pwm + 1) % 256;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        ncmp++;
        if ({dv, wr_ready} !== {32'h0, 1'b1}) begin
            nfail++; $display("FAIL reset_state: got %h/%b want 00000000/1", dv, wr_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        start = 1'b1; clk_cycle(); start = 1'b0;
        ncmp++;
        if ({running, color} !== {1'b1, 24'hFF0000}) begin
            nfail++; $display("FAIL seq_start: got run=%b color=%h want 1 ff0000", running, color);
        end
        for (int k = 1; k <= 16 * NS; k++) begin
            clk_cycle();
            ncmp++;
            if (dv !== exp_vec()) begin
                nfail++; $display("FAIL seq_model k=%0d: got %h want %h", k, dv, exp_vec());
            end
            if (k == 15) begin
                ncmp++;
                if (step_tick !== 1'b0) begin
                    nfail++; $display("FAIL seq_early_tick: got %b want 0", step_tick);
                end
            end
            if (k == 16) begin
                ncmp++;
                if ({step_tick, step_idx, color} !== {1'b1, 3'd1, 24'h00FF00}) begin
                    nfail++; $display("FAIL seq_first_tick: got %b %0d %h want 1 1 00ff00",
                                      step_tick, step_idx, color);
                end
            end
            if (k == 16 * NS) begin
                ncmp++;
                if ({step_tick, step_idx, color} !== {1'b1, 3'd0, 24'hFF0000}) begin
                    nfail++; $display("FAIL seq_wrap: got %b %0d %h want 1 0 ff0000",
                                      step_tick, step_idx, color);
                end
            end
        end
        stop = 1'b1; clk_cycle(); stop = 1'b0;
    endtask

    task automatic test_pause();
        int e = 0, tick_at = -1;
        start = 1'b1; clk_cycle(); start = 1'b0;
        repeat (7) begin clk_cycle(); e++; end
        pause = 1'b1;
        repeat (5) begin
            clk_cycle(); e++;
            ncmp++;
            if ({running, step_idx, step_tick} !== {1'b1, 3'd0, 1'b0}) begin
                nfail++; $display("FAIL pause_hold: got run=%b idx=%0d tick=%b want 1 0 0",
                                  running, step_idx, step_tick);
            end
        end
        pause = 1'b0;
        for (int n = 0; n < 40; n++) begin
            clk_cycle(); e++;
            if (step_tick === 1'b1) begin tick_at = e; break; end
        end
        ncmp++;
        if (tick_at != 21) begin
            nfail++; $display("FAIL pause_delay: tick at edge %0d want 21", tick_at);
        end
        ncmp++;
        if (dv !== exp_vec()) begin
            nfail++; $display("FAIL pause_model: got %h want %h", dv, exp_vec());
        end
        stop = 1'b1; clk_cycle(); stop = 1'b0;
    endtask

    task automatic test_write();
        start = 1'b1; clk_cycle(); start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'h123456;
        clk_cycle(); wr_en = 1'b0;
        ncmp++;
        if ({pre_ready, color} !== {1'b1, 24'h123456}) begin
            nfail++; $display("FAIL wr_current: got rdy=%b color=%h want 1 123456", pre_ready, color);
        end
        for (int g = 0; g < 40 && m_cnt != 15; g++) clk_cycle();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'hABCDEF;
        clk_cycle();
        ncmp++;
        if ({pre_ready, step_idx, color} !== {1'b0, 3'd1, 24'h00FF00}) begin
            nfail++; $display("FAIL wr_collide: got rdy=%b idx=%0d color=%h want 0 1 00ff00",
                              pre_ready, step_idx, color);
        end
        clk_cycle(); wr_en = 1'b0;
        ncmp++;
        if ({pre_ready, color} !== {1'b1, 24'hABCDEF}) begin
            nfail++; $display("FAIL wr_retry: got rdy=%b color=%h want 1 abcdef", pre_ready, color);
        end
        stop = 1'b1; clk_cycle(); stop = 1'b0;
    endtask

    task automatic test_rate();
        start = 1'b1; clk_cycle(); start = 1'b0;
        repeat (10) clk_cycle();
        rate_sel = 2'd3;
        for (int i = 0; i < 6; i++) begin
            clk_cycle();
            ncmp++;
            if (step_tick !== ((i % 2) == 0)) begin
                nfail++; $display("FAIL rate_tick i=%0d: got %b want %b", i, step_tick, (i % 2) == 0);
            end
        end
        rate_sel = 2'd0;
        stop = 1'b1; clk_cycle(); stop = 1'b0;
    endtask

    task automatic test_start_stop_pwm();
        int nr = 0, ng = 0, nb = 0;
        start = 1'b1; clk_cycle(); start = 1'b0;
        repeat (3) clk_cycle();
        start = 1'b1; stop = 1'b1; clk_cycle(); start = 1'b0; stop = 1'b0;
        ncmp++;
        if ({running, color} !== {1'b0, 24'h0}) begin
            nfail++; $display("FAIL start_stop: got run=%b color=%h want 0 000000", running, color);
        end
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'h800000; clk_cycle(); wr_en = 1'b0;
        pause = 1'b1; start = 1'b1; clk_cycle(); start = 1'b0;
        ncmp++;
        if ({running, color} !== {1'b1, 24'h800000}) begin
            nfail++; $display("FAIL pwm_setup: got run=%b color=%h want 1 800000", running, color);
        end
        repeat (256) begin
            clk_cycle();
            nr += int'(led_r); ng += int'(led_g); nb += int'(led_b);
        end
        ncmp++;
        if (nr != 128 || ng != 0 || nb != 0) begin
            nfail++; $display("FAIL pwm_duty: got r=%0d g=%0d b=%0d want 128 0 0", nr, ng, nb);
        end
        pause = 1'b0;
        stop = 1'b1; clk_cycle(); stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; clk_cycle(); start = 1'b0;
        repeat (5) clk_cycle();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h555555;
        #1 rst_n = 1'b0;
        #1;
        ncmp++;
        if ({dv, wr_ready} !== {32'h0, 1'b1}) begin
            nfail++; $display("FAIL reset_mid: got %h/%b want 00000000/1", dv, wr_ready);
        end
        wr_en = 1'b0;
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        start = 1'b1; clk_cycle(); start = 1'b0;
        repeat (16) clk_cycle();
        ncmp++;
        if ({step_idx, color} !== {3'd1, 24'h00FF00}) begin
            nfail++; $display("FAIL reset_tab1: got idx=%0d color=%h want 1 00ff00", step_idx, color);
        end
        repeat (16) clk_cycle();
        ncmp++;
        if ({step_idx, color} !== {3'd2, 24'h0000FF}) begin
            nfail++; $display("FAIL reset_tab2: got idx=%0d color=%h want 2 0000ff", step_idx, color);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) rate_sel = 2'($urandom_range(0, 3));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 24'($urandom);
            clk_cycle();
            ncmp++;
            if (pre_ready !== exp_ready) begin
                nfail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, pre_ready, exp_ready);
            end
            ncmp++;
            if (dv !== exp_vec()) begin
                nfail++; $display("FAIL rand_model c=%0d: got %h want %h", c, dv, exp_vec());
            end
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_pause();
        test_write();
        test_rate();
        test_start_stop_pwm();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/color_seq_ctrl.md
COLOR_SEQ_CTRL -- requirements
Module: color_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BASE_HZ, default 1, step rate in Hz at rate_sel=0.
REQ-003 SHALL have parameter NUM_STEPS, default 8, active table entries; legal range 2..8.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begin or restart the sequence at step 0.
REQ-007 SHALL have port stop  input  1  one-cycle pulse; return to idle.
REQ-008 SHALL have port pause  input  1  level; freeze the sequence while high.
REQ-009 SHALL have port rate_sel  input  2  step rate = BASE_HZ << rate_sel.
REQ-010 SHALL have port wr_en  input  1  color-table write request.
REQ-011 SHALL have port wr_addr  input  3  table index.
REQ-012 SHALL have port wr_data  input  24  RGB888 color {R[23:16],G[15:8],B[7:0]}.
REQ-013 SHALL have port wr_ready  output  1  write accepted when wr_en && wr_ready.
REQ-014 SHALL have port color  output  24  currently displayed RGB888 value.
REQ-015 SHALL have port step_idx  output  3  current table index.
REQ-016 SHALL have port step_tick  output  1  one-cycle pulse on each step advance.
REQ-017 SHALL have port running  output  1  high in RUN or PAUSE.
REQ-018 SHALL have ports led_r, led_g, led_b  output  1 each  PWM drive per channel.

Function
REQ-019 SHALL implement FSM states IDLE, RUN and PAUSE, with command priority stop > start > pause.
REQ-020 SHALL go from IDLE to RUN on start, with step_idx=0, prescaler=0 and color=table[0] on the same edge.
REQ-021 SHALL restart on start in RUN or PAUSE: step_idx=0, prescaler=0, state RUN.
REQ-022 SHALL enter IDLE on stop from any state: color=0, step_idx=0, prescaler=0, step_tick=0.
REQ-023 SHALL go from RUN to PAUSE while pause=1, holding prescaler, step_idx and color, and return from PAUSE to RUN when pause=0, resuming the count from the held value.
REQ-024 SHALL use prescaler terminal TERM = (CLK_HZ/BASE_HZ) >> rate_sel; the prescaler counts only in RUN.
REQ-025 SHALL, when prescaler >= TERM-1 in RUN, on that edge assert step_tick, clear the prescaler, and advance step_idx, wrapping NUM_STEPS-1 to 0.
REQ-026 SHALL apply rate_sel changes immediately; because of the >= compare, an over-range count ticks on the next edge.
REQ-027 SHALL update color on the same edge as step_idx, to table[new idx].
REQ-028 SHALL drive wr_ready=0 only in cycles where a step advance occurs on the next edge; otherwise wr_ready=1.
REQ-029 SHALL write an accepted wr_data to table[wr_addr], and when wr_addr==step_idx and running, color shows the new value the next cycle.
REQ-030 SHALL acknowledge writes with wr_addr >= NUM_STEPS and discard the data.
REQ-031 SHALL run an 8-bit PWM counter freely in all states, wrapping 255 to 0, with led_x = (pwm_cnt < channel byte): 0x00 gives always off, 0xFF gives 255/256 duty.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force: state IDLE, prescaler 0, pwm_cnt 0, step_idx 0, color 0, step_tick 0, running 0, led_r/g/b 0, wr_ready 1.
REQ-033 SHALL reset the table to: 0 FF0000, 1 00FF00, 2 0000FF, 3 FFFF00, 4 00FFFF, 5 FF00FF, 6 FFFFFF, 7 000000.
REQ-034 SHALL honour rst_n mid-sequence or mid-write: the sequence is aborted, the pending write is lost, and the table returns to its reset values.

Verification (CLK_HZ=16, BASE_HZ=1, so TERM=16 at rate_sel=0)
REQ-035 SHALL cover: rst_n low mid-RUN -> all outputs at reset values; table[1] reads 00FF00 after restart.
REQ-036 SHALL cover: start, rate_sel=0 -> running=1 and color=FF0000 next edge; step_tick 16 cycles later, step_idx=1, color=00FF00; 8th tick wraps step_idx to 0.
REQ-037 SHALL cover: pause held 5 cycles at prescaler=7 -> next step_tick exactly 5 cycles late; step_idx unchanged during pause.
REQ-038 SHALL cover: write 0x123456 to the current index -> color=123456 next cycle; a write colliding with a tick -> wr_ready=0, data accepted one cycle later.
REQ-039 SHALL cover: rate_sel 0->3 at prescaler=10 -> tick on the next edge, then every 2 cycles.
REQ-040 SHALL cover: start and stop in the same cycle -> IDLE, color=0; color R=0x80 -> led_r high for 128 of each 256 cycles.
